// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single-request memory with wait timeout
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [7:0] TMO   = 8'(TIMEOUT);

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic        last_d;
   logic        cur_d;
   logic        grant_d;
   logic        timeout;
   logic [31:0] cap_data;

   // Winner when both request: the port that was not granted last time.
   assign grant_d  = (if_req && d_req) ? !last_d : d_req;
   assign timeout  = (cnt + 8'd1) == TMO;
   assign cap_data = mem_ready ? mem_rdata : 32'd0;

   // Control FSM, latched memory request and completion outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         last_d    <= 1'b1;
         cur_d     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= 32'd0;
         d_rdata   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req || d_req) begin
                  state     <= ISSUE;
                  cnt       <= 8'd0;
                  cur_d     <= grant_d;
                  last_d    <= grant_d;
                  mem_req   <= 1'b1;
                  mem_addr  <= grant_d ? d_addr : if_addr;
                  mem_we    <= grant_d && d_we;
                  mem_wdata <= (grant_d && d_we) ? d_wdata : 32'd0;
               end
            end
            ISSUE: begin
               if (!mem_ready)
                  cnt <= cnt + 8'd1;
               if (mem_ready || timeout) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  if_ack  <= !cur_d;
                  d_ack   <= cur_d;
                  err     <= !mem_ready;
                  if (!cur_d)
                     if_rdata <= cap_data;
                  else if (!mem_we)
                     d_rdata <= cap_data;
               end
            end
            DONE: begin
               state  <= IDLE;
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
               err    <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               if_ack  <= 1'b0;
               d_ack   <= 1'b0;
               err     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level randomized check of mem_arbiter against a reference model
module tb_mem_arbiter;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_chk = 0;
   int n_fail = 0;

   bit          last_d = 1'b1;
   logic [31:0] exp_if = '0;
   logic [31:0] exp_d = '0;

   mem_arbiter #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the falling edge of a cycle in which the DUT is idle.
   // rk = ISSUE cycle (1-based) on which mem_ready is raised; 0 = never.
   task automatic txn(input bit rf, input bit rd, input logic [31:0] fa, input logic [31:0] da,
                      input logic [31:0] dwd, input bit we, input int rk,
                      input logic [31:0] rdv, input bit keep);
      bit          win_d;
      bit          e;
      bit          ewe;
      int          n;
      logic [31:0] ea;
      logic [31:0] ewd;
      logic [31:0] got;
      if (rf && !if_req) begin if_req = 1'b1; if_addr = fa; end
      if (rd && !d_req) begin d_req = 1'b1; d_addr = da; d_wdata = dwd; d_we = we; end
      if (!if_req && !d_req) begin if_req = 1'b1; if_addr = fa; end
      win_d  = (if_req && d_req) ? !last_d : d_req;
      last_d = win_d;
      ea     = win_d ? d_addr : if_addr;
      ewe    = win_d && d_we;
      ewd    = ewe ? d_wdata : 32'd0;
      e      = (rk == 0) || (rk > TIMEOUT);
      n      = e ? TIMEOUT : rk;
      got    = e ? 32'd0 : rdv;
      @(negedge clk);
      for (int k = 1; k <= n; k++) begin
         check("issue_req", {31'd0, mem_req}, 32'd1);
         check("issue_addr", mem_addr, ea);
         check("issue_we", {31'd0, mem_we}, {31'd0, ewe});
         check("issue_wdata", mem_wdata, ewd);
         check("issue_noack", {30'd0, if_ack, d_ack}, 32'd0);
         mem_ready = (k == rk);
         mem_rdata = (k == rk) ? rdv : $urandom;
         @(negedge clk);
      end
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      if (!win_d) exp_if = got;
      else if (!ewe) exp_d = got;
      check("done_req", {31'd0, mem_req}, 32'd0);
      check("done_acks", {30'd0, if_ack, d_ack}, {30'd0, !win_d, win_d});
      check("done_err", {31'd0, err}, {31'd0, e});
      check("if_rdata", if_rdata, exp_if);
      check("d_rdata", d_rdata, exp_d);
      if (!keep) begin
         if (win_d) d_req = 1'b0;
         else if_req = 1'b0;
      end
      @(negedge clk);
      mem_ready = 1'($urandom);
      check("idle_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
      check("idle_req", {31'd0, mem_req}, 32'd0);
   endtask

   initial begin
      @(negedge clk);
      check("rst_mem", {mem_req, mem_we, 30'd0}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_out", {29'd0, if_ack, d_ack, err}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      reset = 1'b0;
      // Fetch read, ready on first ISSUE cycle
      txn(1, 0, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF, 0);
      // Tie alternation: fetch, then pending data, then fetch again
      reset = 1'b1; @(negedge clk); reset = 1'b0; last_d = 1'b1; exp_if = 0; exp_d = 0;
      txn(1, 1, 32'h200, 32'h300, 0, 0, 1, 32'h11111111, 0);
      txn(0, 0, 32'h0, 32'h0, 0, 0, 2, 32'h22222222, 0);
      txn(1, 1, 32'h204, 32'h304, 0, 0, 1, 32'h33333333, 0);
      txn(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h44444444, 0);
      // Store with 3 wait cycles
      txn(0, 1, 0, 32'h2000, 32'h12345678, 1, 4, 32'hCAFEF00D, 0);
      // Timeout and ready coincident with timeout
      txn(1, 0, 32'h400, 0, 0, 0, 0, 32'h55555555, 0);
      txn(0, 1, 0, 32'h500, 0, 0, 0, 32'h66666666, 0);
      txn(1, 0, 32'h404, 0, 0, 0, TIMEOUT, 32'h77777777, 0);
      // Reset during 2nd ISSUE cycle with d_req held
      d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_issue_req", {31'd0, mem_req}, 32'd0);
      check("rst_issue_ack", {30'd0, if_ack, d_ack}, 32'd0);
      @(negedge clk);
      reset = 1'b0; last_d = 1'b1; exp_if = 0; exp_d = 0;
      check("rst_issue_noack", {30'd0, if_ack, d_ack}, 32'd0);
      txn(0, 0, 0, 0, 0, 0, 1, 32'h88888888, 0);
      // Randomized traffic
      for (int i = 0; i < 300; i++)
         txn(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
             $urandom_range(0, 18), $urandom, ($urandom_range(0, 3) == 0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
